// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Optional madd/maddu accumulate support is enabled by defining MDU_MADD_EN.
`timescale 1ns/1ps
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  E_op,
   input  logic [5:0]  E_fuc,
   input  logic        E_md_en,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   output logic        md_start,
   output logic        md_busy,
   output logic [31:0] md_out,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        dbg_state
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   typedef enum logic [2:0] {
      OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU
   } md_op_t;

   state_t        state_q, state_d;
   md_op_t        op_q, new_op;
   logic [CW-1:0] cnt_q;
   logic [31:0]   a_q, b_q;

   logic fuc_op, dec_mult, dec_multu, dec_div, dec_divu;
   logic dec_mfhi, dec_mthi, dec_mflo, dec_mtlo, dec_madd, dec_maddu;
   logic done;

   assign fuc_op    = E_md_en && (E_op == 6'b000000);
   assign dec_mult  = fuc_op && (E_fuc == 6'b011000);
   assign dec_multu = fuc_op && (E_fuc == 6'b011001);
   assign dec_div   = fuc_op && (E_fuc == 6'b011010);
   assign dec_divu  = fuc_op && (E_fuc == 6'b011011);
   assign dec_mfhi  = fuc_op && (E_fuc == 6'b010000);
   assign dec_mthi  = fuc_op && (E_fuc == 6'b010001);
   assign dec_mflo  = fuc_op && (E_fuc == 6'b010010);
   assign dec_mtlo  = fuc_op && (E_fuc == 6'b010011);
`ifdef MDU_MADD_EN
   assign dec_madd  = E_md_en && (E_op == 6'b011100) && (E_fuc == 6'b000000);
   assign dec_maddu = E_md_en && (E_op == 6'b011100) && (E_fuc == 6'b000001);
`else
   assign dec_madd  = 1'b0;
   assign dec_maddu = 1'b0;
`endif

   always_comb begin
      new_op = OP_NONE;
      if (dec_mult)       new_op = OP_MULT;
      else if (dec_multu) new_op = OP_MULTU;
      else if (dec_div)   new_op = OP_DIV;
      else if (dec_divu)  new_op = OP_DIVU;
      else if (dec_madd)  new_op = OP_MADD;
      else if (dec_maddu) new_op = OP_MADDU;
   end

   // Handshake: md_start is the accept strobe. A start-class op is taken on the
   // edge where it is valid (decoded with E_md_en) and the unit is ready
   // (md_busy low); an op offered while busy is dropped, never queued.
   assign md_busy   = (state_q == S_RUN);
   assign md_start  = (new_op != OP_NONE) && !md_busy;
   assign md_out    = dec_mfhi ? HI : (dec_mflo ? LO : 32'd0);
   assign dbg_state = state_q;
   assign done      = (state_q == S_RUN) && (cnt_q == CW'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (md_start) state_d = S_RUN;
         S_RUN:   if (done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         op_q  <= OP_NONE;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
      end else if (md_start) begin
         cnt_q <= (new_op == OP_DIV || new_op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
         op_q  <= new_op;
         a_q   <= E_rs;
         b_q   <= E_rt;
      end else if (state_q == S_RUN) begin
         cnt_q <= cnt_q - CW'(1);
         if (done) op_q <= OP_NONE;
      end
   end

   // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly.
   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, sdiv_b, udiv_b, qmag, rmag, quo_s, rem_s, quo_u, rem_u;

   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};
   assign abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
   assign abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
   assign sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
   assign udiv_b = (b_q == 32'd0) ? 32'd1 : b_q;
   assign qmag   = abs_a / sdiv_b;
   assign rmag   = abs_a % sdiv_b;
   assign quo_s  = (a_q[31] ^ b_q[31]) ? (32'd0 - qmag) : qmag;
   assign rem_s  = a_q[31] ? (32'd0 - rmag) : rmag;
   assign quo_u  = a_q / udiv_b;
   assign rem_u  = a_q % udiv_b;

   logic        wr_en;
   logic [63:0] wr_val;

   always_comb begin
      wr_en  = 1'b0;
      wr_val = {HI, LO};
      case (op_q)
         OP_MULT:  begin wr_en = 1'b1; wr_val = prod_s; end
         OP_MULTU: begin wr_en = 1'b1; wr_val = prod_u; end
         OP_DIV:   begin wr_en = (b_q != 32'd0); wr_val = {rem_s, quo_s}; end
         OP_DIVU:  begin wr_en = (b_q != 32'd0); wr_val = {rem_u, quo_u}; end
`ifdef MDU_MADD_EN
         OP_MADD:  begin wr_en = 1'b1; wr_val = {HI, LO} + prod_s; end
         OP_MADDU: begin wr_en = 1'b1; wr_val = {HI, LO} + prod_u; end
`endif
         default:  begin wr_en = 1'b0; wr_val = {HI, LO}; end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (done) begin
         if (wr_en) begin
            HI <= wr_val[63:32];
            LO <= wr_val[31:0];
         end
      end else if (!md_busy) begin
         if (dec_mthi) HI <= E_rs;
         if (dec_mtlo) LO <= E_rs;
      end
   end

endmodule
